// File: rtl/top_pkg.sv
// ============================================================================
// Module   : top_pkg
// Brief    : Shared 7-segment constants: segment bit indices, hex glyph table,
//            all-off code and glyph lookup helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam seg_t SEG_ALL_OFF = 8'h00;

  // Active-high glyphs, entry 0 first; dp is clear in every entry.
  localparam logic [0:15][7:0] SEG_TABLE = {
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic seg_t seg_lookup(input nibble_t nib);
    seg_t s;
    s = SEG_TABLE[nib];
    s[SEG_DP] = 1'b0;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_7seg.sv
// ============================================================================
// Module   : hex_to_7seg
// Brief    : Combinational nibble to active-high 7-segment glyph decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_7seg
  import top_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_lookup(nibble_i);

endmodule

`default_nettype wire

// File: rtl/top.sv
// ============================================================================
// Module   : top
// Brief    : Registered two-digit hex display driver for one byte. Optional
//            high-digit leading-zero blanking via TOP_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top
  import top_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Value,
  output logic [7:0] SevenSegDig1,
  output logic [7:0] SevenSegDig2
);

  localparam seg_t C_POL_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam seg_t C_OFF_CODE = SEG_ALL_OFF ^ C_POL_MASK;

  seg_t w_dec_hi;
  seg_t w_dec_lo;
  seg_t w_hi_shown;
  seg_t dig1_d, dig1_q;
  seg_t dig2_d, dig2_q;

  hex_to_7seg u_dec_hi (
    .nibble_i (Value[7:4]),
    .seg_o    (w_dec_hi)
  );

  hex_to_7seg u_dec_lo (
    .nibble_i (Value[3:0]),
    .seg_o    (w_dec_lo)
  );

`ifdef TOP_LEADING_ZERO_BLANK_EN
  assign w_hi_shown = (Value[7:4] == 4'h0) ? SEG_ALL_OFF : w_dec_hi;
`else
  assign w_hi_shown = w_dec_hi;
`endif

  // Polarity applied last so blanking and reset both yield "all off".
  assign dig1_d = w_hi_shown ^ C_POL_MASK;
  assign dig2_d = w_dec_lo   ^ C_POL_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      dig1_q <= C_OFF_CODE;
      dig2_q <= C_OFF_CODE;
    end else begin
      dig1_q <= dig1_d;
      dig2_q <= dig2_d;
    end
  end

  assign SevenSegDig1 = dig1_q;
  assign SevenSegDig2 = dig2_q;

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ============================================================================
// Module   : tb_top
// Brief    : Self-checking bench for top, both polarities side by side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top;

  logic       clk;
  logic       rst;
  logic [7:0] Value;
  logic [7:0] hi_h, lo_h, hi_l, lo_l;

  int checks = 0;
  int errors = 0;

`ifdef TOP_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic [7:0] seg_ref [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  top #(.SEG_ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .Value(Value), .SevenSegDig1(hi_h), .SevenSegDig2(lo_h)
  );

  top #(.SEG_ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .Value(Value), .SevenSegDig1(hi_l), .SevenSegDig2(lo_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display code for a digit of byte v after one edge.
  function automatic logic [7:0] exp_seg(input logic [7:0] v, input bit hi,
                                         input bit al, input bit in_rst);
    logic [3:0] nib;
    logic [7:0] r;
    nib = hi ? v[7:4] : v[3:0];
    if (in_rst || (BLANK && hi && nib == 4'h0)) r = 8'h00;
    else r = seg_ref[nib];
    return al ? ~r : r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Value = 8'hA5;
    step();
    checks += 4;
    if (hi_h !== 8'h00) begin errors++; $display("FAIL reset_hi_h got %h exp 00", hi_h); end
    if (lo_h !== 8'h00) begin errors++; $display("FAIL reset_lo_h got %h exp 00", lo_h); end
    if (hi_l !== 8'hFF) begin errors++; $display("FAIL reset_hi_l got %h exp FF", hi_l); end
    if (lo_l !== 8'hFF) begin errors++; $display("FAIL reset_lo_l got %h exp FF", lo_l); end
    rst = 1'b0;
    step();
    checks += 4;
    if (hi_h !== 8'h77) begin errors++; $display("FAIL release_hi_h got %h exp 77", hi_h); end
    if (lo_h !== 8'h6D) begin errors++; $display("FAIL release_lo_h got %h exp 6D", lo_h); end
    if (hi_l !== 8'h88) begin errors++; $display("FAIL release_hi_l got %h exp 88", hi_l); end
    if (lo_l !== 8'h92) begin errors++; $display("FAIL release_lo_l got %h exp 92", lo_l); end
  endtask

  task automatic test_value06();
    logic [7:0] e1h, e1l;
    e1h = BLANK ? 8'h00 : 8'h3F;
    e1l = BLANK ? 8'hFF : 8'hC0;
    Value = 8'h06;
    step();
    checks += 4;
    if (hi_h !== e1h)   begin errors++; $display("FAIL v06_hi_h got %h exp %h", hi_h, e1h); end
    if (lo_h !== 8'h7D) begin errors++; $display("FAIL v06_lo_h got %h exp 7D", lo_h); end
    if (hi_l !== e1l)   begin errors++; $display("FAIL v06_hi_l got %h exp %h", hi_l, e1l); end
    if (lo_l !== 8'h82) begin errors++; $display("FAIL v06_lo_l got %h exp 82", lo_l); end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      Value = 8'(v);
      step();
      checks += 5;
      if (hi_h !== exp_seg(8'(v), 1, 0, 0)) begin errors++;
        $display("FAIL sweep_hi_h v=%h got %h exp %h", v, hi_h, exp_seg(8'(v), 1, 0, 0)); end
      if (lo_h !== exp_seg(8'(v), 0, 0, 0)) begin errors++;
        $display("FAIL sweep_lo_h v=%h got %h exp %h", v, lo_h, exp_seg(8'(v), 0, 0, 0)); end
      if (hi_l !== exp_seg(8'(v), 1, 1, 0)) begin errors++;
        $display("FAIL sweep_hi_l v=%h got %h exp %h", v, hi_l, exp_seg(8'(v), 1, 1, 0)); end
      if (lo_l !== exp_seg(8'(v), 0, 1, 0)) begin errors++;
        $display("FAIL sweep_lo_l v=%h got %h exp %h", v, lo_l, exp_seg(8'(v), 0, 1, 0)); end
      if (hi_h[7] !== 1'b0 || lo_h[7] !== 1'b0) begin errors++;
        $display("FAIL sweep_dp v=%h got %b%b exp 00", v, hi_h[7], lo_h[7]); end
    end
  endtask

  task automatic test_hold();
    Value = 8'h12;
    step();
    Value = 8'h34;
    #3;
    checks += 2;
    if (hi_h !== 8'h06) begin errors++; $display("FAIL hold_hi got %h exp 06", hi_h); end
    if (lo_h !== 8'h5B) begin errors++; $display("FAIL hold_lo got %h exp 5B", lo_h); end
    step();
    checks += 2;
    if (hi_h !== 8'h4F) begin errors++; $display("FAIL upd_hi got %h exp 4F", hi_h); end
    if (lo_h !== 8'h66) begin errors++; $display("FAIL upd_lo got %h exp 66", lo_h); end
  endtask

  task automatic test_blank();
    logic [7:0] e;
    e = BLANK ? 8'h00 : 8'h3F;
    Value = 8'h0F;
    step();
    checks += 2;
    if (hi_h !== e)     begin errors++; $display("FAIL blank0F_hi got %h exp %h", hi_h, e); end
    if (lo_h !== 8'h71) begin errors++; $display("FAIL blank0F_lo got %h exp 71", lo_h); end
    Value = 8'h10;
    step();
    checks += 2;
    if (hi_h !== 8'h06) begin errors++; $display("FAIL blank10_hi got %h exp 06", hi_h); end
    if (lo_h !== 8'h3F) begin errors++; $display("FAIL blank10_lo got %h exp 3F", lo_h); end
  endtask

  // Random values with sporadic mid-operation resets.
  task automatic test_random();
    logic [7:0] v;
    bit         r;
    for (int i = 0; i < 200; i++) begin
      v = 8'($urandom);
      r = ($urandom_range(0, 7) == 0);
      Value = v; rst = r;
      step();
      checks += 4;
      if (hi_h !== exp_seg(v, 1, 0, r)) begin errors++;
        $display("FAIL rand_hi_h v=%h rst=%0d got %h exp %h", v, r, hi_h, exp_seg(v, 1, 0, r)); end
      if (lo_h !== exp_seg(v, 0, 0, r)) begin errors++;
        $display("FAIL rand_lo_h v=%h rst=%0d got %h exp %h", v, r, lo_h, exp_seg(v, 0, 0, r)); end
      if (hi_l !== exp_seg(v, 1, 1, r)) begin errors++;
        $display("FAIL rand_hi_l v=%h rst=%0d got %h exp %h", v, r, hi_l, exp_seg(v, 1, 1, r)); end
      if (lo_l !== exp_seg(v, 0, 1, r)) begin errors++;
        $display("FAIL rand_lo_l v=%h rst=%0d got %h exp %h", v, r, lo_l, exp_seg(v, 0, 1, r)); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Value = 8'h00;
    test_reset();
    test_value06();
    test_sweep();
    test_hold();
    test_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 0, meaning 0 = segment lit by 1 (common cathode) and 1 = all 8 output bits inverted (common anode).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 SHALL have port Value, input, 8 bits, the byte to display in hexadecimal.
REQ-005 SHALL have port SevenSegDig1, output, 8 bits, the high-nibble digit (Value[7:4]).
REQ-006 SHALL have port SevenSegDig2, output, 8 bits, the low-nibble digit (Value[3:0]).
REQ-007 SHALL use output bit map bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.

Function
REQ-008 SHALL decode each nibble in the active-high sense as follows:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-009 SHALL keep dp (bit7) at 0 in the active-high sense for every value.
REQ-010 SHALL register both outputs: a Value present before rising edge N appears on the outputs after edge N (latency 1 cycle).
REQ-011 SHALL hold the outputs stable between clock edges regardless of Value changes.
REQ-012 SHALL show a leading zero as "0" (3F) on SevenSegDig1 when blanking is not compiled in.
REQ-013 SHALL invert all 8 bits of both outputs, including dp and reset values, when SEG_ACTIVE_LOW=1.
REQ-014 SHALL decode each digit independently; both digits update on the same edge with no skew.

Reset
REQ-015 SHALL drive both outputs to all segments off on a rising edge with rst=1: 8'h00, or 8'hFF when SEG_ACTIVE_LOW=1.
REQ-016 SHALL give rst priority over a Value update on the same edge.
REQ-017 SHALL show the decode of the Value present at the first edge after rst is deasserted.
REQ-018 SHALL, when rst is asserted mid-operation, blank the outputs on that edge with no residual decode.

Configuration
REQ-019 SHALL support macro TOP_LEADING_ZERO_BLANK_EN.
REQ-020 SHALL, with TOP_LEADING_ZERO_BLANK_EN defined, drive SevenSegDig1 to all segments off whenever Value[7:4]==0; SevenSegDig2 is never blanked.
REQ-021 SHALL, without TOP_LEADING_ZERO_BLANK_EN, show the high digit always as decoded.

Structure
REQ-022 SHALL place in shared package top_pkg:
  - the 16-entry segment constant table
  - the segment bit-index constants
  - the all-off constant
REQ-023 SHALL implement the decoder as sub-module hex_to_7seg (4-bit in, 8-bit active-high out), instantiated twice in top.
REQ-024 SHALL apply polarity inversion, blanking and output registers in top only.

Verification
REQ-025 SHALL check: Value=0x06, one edge -> SevenSegDig1=00111111, SevenSegDig2=01111101.
REQ-026 SHALL check: sweep Value 0x00..0xFF -> each digit matches the REQ-008 table; dp=0 throughout.
REQ-027 SHALL check: rst=1 with Value=0xA5 -> both outputs 8'h00; first edge after release -> 77 / 6D.
REQ-028 SHALL check: Value changes 0x12->0x34 between edges -> outputs stay 06/5B until the next edge, then 4F/66.
REQ-029 SHALL check: SEG_ACTIVE_LOW=1 with Value=0x06 -> C0 / 82; under reset -> FF / FF.
REQ-030 SHALL check: TOP_LEADING_ZERO_BLANK_EN defined with Value=0x0F -> SevenSegDig1=00, SevenSegDig2=71; Value=0x10 -> 06 / 3F.
